can_rx_destuffer: RTL

CAN_RX_DESTUFFER -- requirements
Module: can_rx_destuffer

---
 rtl/can_rx_destuffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/can_rx_destuffer.sv
// ---------------------------------------------------------------------------
// can_rx_destuffer
//   CAN receive-side bit destuffer with CRC-15 accumulation.
//   It tracks runs of equal bits inside the stuffing window. It flags the bit
//   that follows STUFF_LEN equal bits as a stuff bit, so downstream skips it.
//   It reports a stuff-rule violation and accumulates CRC-15 over the
//   non-stuff bits.
//
// Ports
//   clk              : clock, all state changes on rising edge
//   rst              : asynchronous active-high reset
//   rx_bit_curr      : synchronized bus bit, valid with sample_point
//   sample_point     : one-cycle strobe at the sample instant of a bit
//   destuff_en       : stuffing window (SOF through last CRC bit)
//   crc_en           : CRC coverage window (SOF through last CRC bit)
//   crc_clear        : synchronous clear of CRC register and stuff counter
//   remove_stuff_bit : combinational, current sampled bit is a stuff bit
//   stuff_err        : registered one-cycle pulse on a stuff violation
//   crc_calc         : current CRC register
//   crc_ok           : combinational, crc_calc == 0
//   stuff_cnt        : stuff bits removed since last crc_clear, saturating
// ---------------------------------------------------------------------------
module can_rx_destuffer #(
  parameter int unsigned STUFF_LEN = 5,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit_curr,
  input  logic        sample_point,
  input  logic        destuff_en,
  input  logic        crc_en,
  input  logic        crc_clear,
  output logic        remove_stuff_bit,
  output logic        stuff_err,
  output logic [14:0] crc_calc,
  output logic        crc_ok,
  output logic [7:0]  stuff_cnt
);

  localparam int unsigned RUN_W = 3;
  localparam int unsigned CRC_W = 15;
  localparam int unsigned CNT_W = 8;
  localparam logic [RUN_W-1:0] RUN_STUFF = RUN_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic             last_bit, last_bit_nxt;
  logic [CRC_W-1:0] crc_reg, crc_reg_nxt;
  logic [CNT_W-1:0] cnt_reg, cnt_reg_nxt;
  logic             err_reg, err_reg_nxt;
  logic             at_stuff;
  logic             crc_fb;

  // Stuff position: the run has reached its limit, so this strobe carries a stuff bit
  assign at_stuff         = (run_cnt == RUN_STUFF);
  assign remove_stuff_bit = sample_point & destuff_en & at_stuff;
  assign crc_fb           = rx_bit_curr ^ crc_reg[CRC_W-1];

  // Next-state logic for run tracking, CRC and stuff bookkeeping
  always_comb begin
    run_cnt_nxt  = run_cnt;
    last_bit_nxt = last_bit;
    crc_reg_nxt  = crc_reg;
    cnt_reg_nxt  = cnt_reg;
    err_reg_nxt  = 1'b0;

    if (sample_point) begin
      if (!destuff_en) begin
        // Outside the window: arm for the next frame; recessive is the idle level
        run_cnt_nxt  = '0;
        last_bit_nxt = 1'b1;
      end else if (at_stuff) begin
        // A stuff bit also starts the next run
        run_cnt_nxt  = RUN_W'(1);
        last_bit_nxt = rx_bit_curr;
        if (rx_bit_curr != last_bit) begin
          if (cnt_reg != CNT_MAX) begin
            cnt_reg_nxt = cnt_reg + CNT_W'(1);
          end
        end else begin
          err_reg_nxt = 1'b1;
        end
      end else begin
        if ((run_cnt == '0) || (rx_bit_curr != last_bit)) begin
          run_cnt_nxt = RUN_W'(1);
        end else begin
          run_cnt_nxt = run_cnt + RUN_W'(1);
        end
        last_bit_nxt = rx_bit_curr;
        if (crc_en) begin
          crc_reg_nxt = {crc_reg[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
        end
      end
    end

    // Clear wins over any same-cycle update of CRC and counter
    if (crc_clear) begin
      crc_reg_nxt = '0;
      cnt_reg_nxt = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      last_bit <= 1'b1;
      crc_reg  <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      run_cnt  <= run_cnt_nxt;
      last_bit <= last_bit_nxt;
      crc_reg  <= crc_reg_nxt;
      cnt_reg  <= cnt_reg_nxt;
      err_reg  <= err_reg_nxt;
    end
  end

  assign stuff_err = err_reg;
  assign crc_calc  = crc_reg;
  assign crc_ok    = (crc_reg == '0);
  assign stuff_cnt = cnt_reg;

endmodule
